piece_pattern_fetch: RTL

- Reader side of the tetromino pattern ROM.
- Accepts a (shape, rotation, anchor) request and drives the ROM address. It then latches the packed pattern word.
- Unpacks the word into four cell offsets, adds the anchor, and streams four absolute board coordinates, one per accepted beat.
- Sits between the game-control FSM and the board collision/draw logic.

---
 rtl/piece_pattern_fetch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/piece_pattern_fetch.sv
// Tetromino pattern reader: fetches a packed pattern word from a combinational ROM
// and streams four absolute cell coordinates. Optional bounds flag: PATTERN_BOUNDS_CHECK_EN.
module piece_pattern_fetch #(
  parameter int width_p   = 24,
  parameter int depth_p   = 32,
  parameter int board_w_p = 10,
  parameter int board_h_p = 20
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           req_v_i,
  output logic                           req_ready_o,
  input  logic [2:0]                     shape_i,
  input  logic [1:0]                     rot_i,
  input  logic [$clog2(board_w_p)-1:0]   anchor_x_i,
  input  logic [$clog2(board_h_p)-1:0]   anchor_y_i,
  output logic [$clog2(depth_p)-1:0]     rom_addr_o,
  input  logic [width_p-1:0]             rom_data_i,
  output logic                           cell_v_o,
  input  logic                           cell_ready_i,
  output logic [$clog2(board_w_p):0]     cell_x_o,
  output logic [$clog2(board_h_p):0]     cell_y_o,
  output logic [1:0]                     cell_idx_o,
  output logic                           cell_last_o,
  output logic                           cell_oob_o,
  output logic [1:0]                     state_o
);

  localparam int aw_lp  = $clog2(depth_p);
  localparam int xw_lp  = $clog2(board_w_p);
  localparam int yw_lp  = $clog2(board_h_p);
  localparam int cxw_lp = xw_lp + 1;
  localparam int cyw_lp = yw_lp + 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and a raised valid holds its payload stable
  // until the transfer completes.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [aw_lp-1:0]      addr_q;
  logic [xw_lp-1:0]      anchor_x_q;
  logic [yw_lp-1:0]      anchor_y_q;
  logic [width_p-1:0]    word_q;
  logic [1:0]            idx_q;

  logic                  accept;
  logic                  beat_done;
  logic                  emit;
  logic [5:0]            cell_bits;
  logic [2:0]            dx;
  logic [2:0]            dy;
  logic [cxw_lp-1:0]     sum_x;
  logic [cyw_lp-1:0]     sum_y;

  assign emit      = (state_q == EMIT);
  assign accept    = (state_q == IDLE) && req_v_i;
  assign beat_done = emit && cell_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   state_d = EMIT;
      EMIT:    if (beat_done && (idx_q == 2'd3)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture: later input changes are ignored until the next IDLE accept.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q     <= '0;
      anchor_x_q <= '0;
      anchor_y_q <= '0;
    end else if (accept) begin
      addr_q     <= aw_lp'({shape_i, rot_i});
      anchor_x_q <= anchor_x_i;
      anchor_y_q <= anchor_y_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_q <= '0;
      idx_q  <= 2'd0;
    end else if (state_q == FETCH) begin
      word_q <= rom_data_i;
      idx_q  <= 2'd0;
    end else if (beat_done && (idx_q != 2'd3)) begin
      idx_q  <= idx_q + 2'd1;
    end
  end

  always_comb begin
    cell_bits = word_q[5:0];
    case (idx_q)
      2'd1:    cell_bits = word_q[11:6];
      2'd2:    cell_bits = word_q[17:12];
      2'd3:    cell_bits = word_q[23:18];
      default: cell_bits = word_q[5:0];
    endcase
  end

  assign dx = cell_bits[2:0];
  assign dy = cell_bits[5:3];

  // One extra bit on each sum so anchor + 7 never wraps.
  assign sum_x = cxw_lp'(anchor_x_q) + cxw_lp'(dx);
  assign sum_y = cyw_lp'(anchor_y_q) + cyw_lp'(dy);

  assign req_ready_o = (state_q == IDLE);
  assign rom_addr_o  = addr_q;
  assign cell_v_o    = emit;
  assign cell_x_o    = emit ? sum_x : '0;
  assign cell_y_o    = emit ? sum_y : '0;
  assign cell_idx_o  = emit ? idx_q : 2'd0;
  assign cell_last_o = emit && (idx_q == 2'd3);
  assign state_o     = state_q;

`ifdef PATTERN_BOUNDS_CHECK_EN
  localparam logic [cxw_lp-1:0] board_w_c = cxw_lp'(board_w_p);
  localparam logic [cyw_lp-1:0] board_h_c = cyw_lp'(board_h_p);
  assign cell_oob_o = emit && ((sum_x >= board_w_c) || (sum_y >= board_h_c));
`else
  assign cell_oob_o = 1'b0;
`endif

endmodule
